// File: rtl/util_pkg.sv
// util_pkg
// Shared helpers for the serial datapath units.
//   clog2     : ceiling log2 of a positive integer (constant-function safe)
//   frame_len : number of shift steps that move a full word through a register
package util_pkg;

    // Smallest r such that 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Frame length: shifts of 'step' bits needed to pass a 'width'-bit word.
    function automatic int frame_len(input int width, input int step);
        return width / step;
    endfunction

endpackage

// File: rtl/shift_buffer_ex_frame_counter.sv
// frame_counter
// Modulo-F event counter with synchronous clear and a registered wrap pulse.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   clear in  return count to zero, suppress wrap (has priority over en)
//   en    in  count one event
//   count out events seen since the last clear/wrap (0 .. F-1)
//   wrap  out one-cycle pulse in the cycle after the F-th event
module frame_counter
    import util_pkg::*;
#(
    parameter int F  = 8,
    parameter int CW = clog2(F + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LastCount = CW'(F - 1);

    logic [CW-1:0] count_r;
    logic          wrap_r;
    logic [CW-1:0] count_next_s;
    logic          wrap_next_s;

    // Next count/wrap: clear beats counting; wrap only on the F-th event.
    always_comb begin
        count_next_s = count_r;
        wrap_next_s  = 1'b0;
        if (clear) begin
            count_next_s = {CW{1'b0}};
            wrap_next_s  = 1'b0;
        end else if (en) begin
            if (count_r == LastCount) begin
                count_next_s = {CW{1'b0}};
                wrap_next_s  = 1'b1;
            end else begin
                count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                wrap_next_s  = 1'b0;
            end
        end else begin
            count_next_s = count_r;
            wrap_next_s  = 1'b0;
        end
    end

    // Counter and wrap pulse registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            wrap_r  <= wrap_next_s;
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;

endmodule

// File: rtl/shift_buffer_ex.sv
// shift_buffer_ex
// Parallel-load shift register moving Step bits per shift, left or right,
// with optional rotation, a serial output and a frame counter that pulses
// 'done' once a full word (Width/Step shifts) has passed through.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high reset (Q=Init, count=0, done=0)
//   we     in  parallel load of D (beats en)
//   D      in  [Width-1:0] parallel load data
//   en     in  shift enable
//   dir    in  0 = toward MSB (left), 1 = toward LSB (right)
//   rotate in  1 = ejected bits re-enter at the opposite end, sin ignored
//   sin    in  [Step-1:0] serial input bits
//   Q      out [Width-1:0] register contents
//   sout   out [Step-1:0] bits the next shift in direction dir will eject
//   count  out shifts completed since last load/wrap
//   done   out one-cycle pulse after a full frame of shifts
module shift_buffer_ex
    import util_pkg::*;
#(
    parameter int                 Width = 8,
    parameter int                 Step  = 1,
    parameter logic [Width-1:0]   Init  = {Width{1'b0}}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [Width-1:0]                  D,
    input  logic                              en,
    input  logic                              dir,
    input  logic                              rotate,
    input  logic [Step-1:0]                   sin,
    output logic [Width-1:0]                  Q,
    output logic [Step-1:0]                   sout,
    output logic [$clog2(Width/Step+1)-1:0]   count,
    output logic                              done
);

    localparam int F  = frame_len(Width, Step);
    localparam int CW = $clog2(Width / Step + 1);

    // Reject geometries where a frame is not a whole number of shifts.
    if ((Width < 2) || (Step < 1) || (Step >= Width) || ((Width % Step) != 0)) begin : g_bad_params
        $error("shift_buffer_ex: need Width>=2, 1<=Step<Width, Width%%Step==0");
    end

    logic [Width-1:0] q_r;
    logic [Width-1:0] next_q_s;
    logic [Step-1:0]  sout_s;

    // Next register value: load beats shift; shift form chosen by dir/rotate.
    always_comb begin
        next_q_s = q_r;
        if (we) begin
            next_q_s = D;
        end else if (en) begin
            case ({dir, rotate})
                2'b00:   next_q_s = {q_r[Width-Step-1:0], sin};
                2'b01:   next_q_s = {q_r[Width-Step-1:0], q_r[Width-1:Width-Step]};
                2'b10:   next_q_s = {sin, q_r[Width-1:Step]};
                2'b11:   next_q_s = {q_r[Step-1:0], q_r[Width-1:Step]};
                default: next_q_s = q_r;
            endcase
        end else begin
            next_q_s = q_r;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= Init;
        end else begin
            q_r <= next_q_s;
        end
    end

    // Serial output: the Step bits at the leading edge for the current dir.
    always_comb begin
        sout_s = q_r[Step-1:0];
        if (dir) begin
            sout_s = q_r[Step-1:0];
        end else begin
            sout_s = q_r[Width-1:Width-Step];
        end
    end

    // A load restarts the frame; only real shifts advance it.
    frame_counter #(
        .F  (F),
        .CW (CW)
    ) u_frame_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (we),
        .en    (en),
        .count (count),
        .wrap  (done)
    );

    assign Q    = q_r;
    assign sout = sout_s;

endmodule
